// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared widths, constants and the buffered-entry type for the instruction
// fetch unit (fetch_unit) and its two-entry buffer (fetch_buf).
// ---------------------------------------------------------------------------
package fetch_pkg;

   localparam int PC_W        = 8;
   localparam int INSTR_W     = 32;
   localparam int FETCH_DEPTH = 2;
   localparam int CNT_W       = $clog2(FETCH_DEPTH + 1);
   localparam int PTR_W       = (FETCH_DEPTH > 1) ? $clog2(FETCH_DEPTH) : 1;

   localparam logic [PC_W-1:0] PC_STEP  = 8'd4;
   localparam logic [PC_W-1:0] RESET_PC = 8'h00;

   // One buffered fetch: the instruction word and the byte PC it came from.
   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
   } fetch_entry_t;

   // Force a byte address onto a word boundary.
   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] p);
      return {p[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_buf.sv
// ---------------------------------------------------------------------------
// fetch_buf
// In-order FIFO of FETCH_DEPTH fetch entries.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data at the tail (ignored when full without pop)
//   push_data  : entry to write
//   pop        : advance the head (ignored when empty)
//   flush      : drop every entry; takes priority over push and pop
//   count      : number of valid entries, 0..FETCH_DEPTH
//   head       : entry at the head (storage contents when empty)
//   head_valid : count != 0
// Push and pop in the same cycle on a full buffer is legal: the slot freed
// by the pop is the one the push fills, so count stays at FETCH_DEPTH.
// ---------------------------------------------------------------------------
module fetch_buf
   import fetch_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  fetch_entry_t       push_data,
   input  logic               pop,
   input  logic               flush,
   output logic [CNT_W-1:0]   count,
   output fetch_entry_t       head,
   output logic               head_valid
);

   localparam logic [CNT_W-1:0] FULL     = CNT_W'(FETCH_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FETCH_DEPTH - 1);

   fetch_entry_t            mem [FETCH_DEPTH];
   logic [PTR_W-1:0]        head_ptr;
   logic [PTR_W-1:0]        tail_ptr;
   logic                    do_push;
   logic                    do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != FULL) || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= '0;
         head_ptr <= '0;
         tail_ptr <= '0;
         for (int i = 0; i < FETCH_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         count    <= '0;
         head_ptr <= '0;
         tail_ptr <= '0;
      end else begin
         if (do_push) begin
            mem[tail_ptr] <= push_data;
            tail_ptr      <= next_ptr(tail_ptr);
         end
         if (do_pop) begin
            head_ptr <= next_ptr(head_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head       = mem[head_ptr];
   assign head_valid = (count != '0);

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Sequential instruction fetch from a combinational instruction memory into
// a two-entry buffer, with branch/jump redirect.
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_address       : word-aligned byte address to inst_mem (straight from pc)
//   instruction     : word returned by inst_mem for i_address, same cycle
//   fetch_en        : 1 = fetch permitted, 0 = hold pc (buffer still drains)
//   redirect_valid  : taken branch/jump; flush buffer, restart at redirect_pc
//   redirect_pc     : restart byte PC, low two bits ignored
//   out_valid       : head entry holds a valid instruction
//   out_ready       : consumer accepts the head this cycle
//   out_instr       : head instruction word
//   out_pc          : byte PC of the head instruction
//   fetch_count     : delivered-instruction counter (FETCH_PERF_CNT_EN only)
// Handshake: an entry transfers on a rising edge where out_valid and
// out_ready are both 1. out_valid never depends on out_ready, and while
// out_valid=1 with out_ready=0 the out_* payload holds its value.
// A redirect at an edge beats everything else: no push, and a coinciding
// transfer is discarded (not delivered, not counted).
// Optional feature macro: FETCH_PERF_CNT_EN (adds fetch_count).
// ---------------------------------------------------------------------------
module fetch_unit
   import fetch_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   output logic [PC_W-1:0]    i_address,
   input  logic [INSTR_W-1:0] instruction,
   input  logic               fetch_en,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]        fetch_count
`endif
);

   localparam logic [CNT_W-1:0] FULL = CNT_W'(FETCH_DEPTH);

   logic [PC_W-1:0]    pc;
   logic [CNT_W-1:0]   count;
   fetch_entry_t       head;
   fetch_entry_t       push_data;
   logic               push;
   logic               pop;
   logic               redirect_lsb_unused;

   // Low bits of the redirect target are dropped by alignment.
   assign redirect_lsb_unused = ^redirect_pc[1:0];

   assign pop       = out_valid && out_ready && !redirect_valid;
   assign push      = fetch_en && !redirect_valid && ((count != FULL) || pop);
   assign push_data = '{instr: instruction, pc: pc};

   // pc is a plain register so i_address has no path from any input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (redirect_valid) begin
         pc <= align_pc(redirect_pc);
      end else if (push) begin
         pc <= pc + PC_STEP;   // wraps modulo 256
      end
   end

   assign i_address = pc;

   fetch_buf u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_data  (push_data),
      .pop        (pop),
      .flush      (redirect_valid),
      .count      (count),
      .head       (head),
      .head_valid (out_valid)
   );

   assign out_instr = head.instr;
   assign out_pc    = head.pc;

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count <= '0;
      end else if (pop) begin
         fetch_count <= fetch_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Bench for fetch_unit: combinational inst_mem model, directed scenarios
// with literal expectations, then randomized traffic checked every cycle
// against a queue-based model of the fetch stream.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  i_address;
   logic [31:0] instruction;
   logic        fetch_en;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [7:0]  out_pc;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_count;
`endif

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Model state: entries {instr, pc} in delivery order, next fetch pc,
   // delivered count.
   logic [39:0] exp_q[$];
   logic [7:0]  m_pc;
   logic [15:0] m_cnt;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- inst_mem ----------------
   function automatic logic [31:0] mem_word(input logic [7:0] a);
      case (a)
         8'h00:   return 32'h21080003;
         8'h04:   return 32'h212900FF;
         8'h08:   return 32'hAD280000;
         default: return 32'h00000000;
      endcase
   endfunction

   assign instruction = mem_word(i_address);

   fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_address      (i_address),
      .instruction    (instruction),
      .fetch_en       (fetch_en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count    (fetch_count)
`endif
   );

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model of one rising edge, using the inputs presented before it.
   task automatic model_edge();
      bit pop_now;
      bit push_now;
      if (!rst_n) return;
      if (redirect_valid) begin
         exp_q.delete();
         m_pc = {redirect_pc[7:2], 2'b00};
      end else begin
         pop_now  = (exp_q.size() > 0) && out_ready;
         push_now = fetch_en && ((exp_q.size() < 2) || pop_now);
         if (pop_now) begin
            void'(exp_q.pop_front());
            m_cnt = m_cnt + 16'd1;
         end
         if (push_now) begin
            exp_q.push_back({mem_word(m_pc), m_pc});
            m_pc = m_pc + 8'd4;
         end
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("i_address", 32'(i_address), 32'(m_pc));
         chk("out_valid", 32'(out_valid), (exp_q.size() != 0) ? 32'd1 : 32'd0);
         if (exp_q.size() != 0) begin
            chk("out_pc", 32'(out_pc), 32'(exp_q[0][7:0]));
            chk("out_instr", out_instr, exp_q[0][39:8]);
         end
`ifdef FETCH_PERF_CNT_EN
         chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
`endif
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   // Asynchronous reset pulse placed between edges; called at a negedge.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      exp_q.delete();
      m_pc  = 8'h00;
      m_cnt = 16'h0000;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_i_address", 32'(i_address), 32'h00);
      chk("rst_out_pc", 32'(out_pc), 32'h00);
      chk("rst_out_instr", out_instr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk("rst_fetch_count", 32'(fetch_count), 32'd0);
`endif
      cyc();
      cyc();
      rst_n = 1'b1;
   endtask

   task automatic chk_head(input string tag, input logic [7:0] pc, input logic [31:0] ins);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_pc"}, 32'(out_pc), 32'(pc));
      chk({tag, "_instr"}, out_instr, ins);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n          = 1'b0;
      fetch_en       = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 8'h00;
      m_pc           = 8'h00;
      m_cnt          = 16'h0000;
      #1;
      chk("init_out_valid", 32'(out_valid), 32'd0);
      chk("init_i_address", 32'(i_address), 32'h00);
      chk("init_out_pc", 32'(out_pc), 32'h00);
      chk("init_out_instr", out_instr, 32'h0);
      chk_en = 1'b1;
      cyc();
      cyc();
      rst_n = 1'b1;

      // Streaming after reset: one instruction per cycle.
      fetch_en  = 1'b1;
      out_ready = 1'b1;
      cyc(); chk_head("s0", 8'h00, 32'h21080003);
      cyc(); chk_head("s1", 8'h04, 32'h212900FF);
      cyc(); chk_head("s2", 8'h08, 32'hAD280000);
      cyc(); chk_head("s3", 8'h0C, 32'h00000000);

      // Back-pressure: buffer fills to two and pc holds.
      do_reset();
      fetch_en  = 1'b1;
      out_ready = 1'b0;
      repeat (5) cyc();
      chk("bp_i_address", 32'(i_address), 32'h08);
      chk_head("bp_hold", 8'h00, 32'h21080003);
      out_ready = 1'b1;
      cyc(); chk_head("bp1", 8'h04, 32'h212900FF);
      cyc(); chk_head("bp2", 8'h08, 32'hAD280000);
      cyc(); chk_head("bp3", 8'h0C, 32'h00000000);

      // Redirect to an unaligned target while full; coinciding pop dropped.
      do_reset();
      fetch_en  = 1'b1;
      out_ready = 1'b0;
      repeat (3) cyc();
      redirect_valid = 1'b1;
      redirect_pc    = 8'h07;
      out_ready      = 1'b1;
      cyc();
      redirect_valid = 1'b0;
      chk("rd_out_valid", 32'(out_valid), 32'd0);
      chk("rd_i_address", 32'(i_address), 32'h04);
      cyc(); chk_head("rd1", 8'h04, 32'h212900FF);

      // Redirect near the top of the address space: pc wraps to 0x00.
      redirect_valid = 1'b1;
      redirect_pc    = 8'hFC;
      cyc();
      redirect_valid = 1'b0;
      chk("wr_out_valid", 32'(out_valid), 32'd0);
      chk("wr_i_address", 32'(i_address), 32'hFC);
      cyc(); chk_head("wr1", 8'hFC, 32'h00000000);
      cyc(); chk_head("wr2", 8'h00, 32'h21080003);

      // Asynchronous reset mid-stream, then restart from 0x00.
      cyc();
      do_reset();
      cyc(); chk_head("ar1", 8'h00, 32'h21080003);
      cyc(); chk_head("ar2", 8'h04, 32'h212900FF);

`ifdef FETCH_PERF_CNT_EN
      // Ten delivered pops, then one pop swallowed by a redirect.
      do_reset();
      fetch_en  = 1'b1;
      out_ready = 1'b1;
      repeat (11) cyc();
      redirect_valid = 1'b1;
      redirect_pc    = 8'h00;
      cyc();
      redirect_valid = 1'b0;
      chk("perf_count", 32'(fetch_count), 32'd10);
`endif

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         fetch_en       = ($urandom_range(0, 7) != 0);
         out_ready      = ($urandom_range(0, 2) != 0);
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc    = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end
         cyc();
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
